// File: rtl/alu_writeback_stage_pkg.sv
// Shared definitions for the ALU writeback stage: opcode encodings, flag
// register layout and the opcode class selectors reused by the decode stage.
package alu_writeback_stage_pkg;

  localparam int OPCODE_BITS = 5;

  typedef enum logic [OPCODE_BITS-1:0] {
    OP_NOP  = 5'h00,
    OP_NOT  = 5'h01,
    OP_AND  = 5'h02,
    OP_OR   = 5'h03,
    OP_XOR  = 5'h04,
    OP_NEG  = 5'h05,
    OP_ADD  = 5'h06,
    OP_SUB  = 5'h07,
    OP_MUL  = 5'h08,
    OP_DIV  = 5'h09,
    OP_MOD  = 5'h0A,
    OP_LD   = 5'h0B,
    OP_STR  = 5'h0C,
    OP_JMP  = 5'h0D,
    OP_JC   = 5'h0E,
    OP_JS   = 5'h0F,
    OP_JO   = 5'h10,
    OP_JZ   = 5'h11,
    OP_HLT  = 5'h12,
    OPD_NOT = 5'h13,
    OPD_AND = 5'h14,
    OPD_OR  = 5'h15,
    OPD_XOR = 5'h16,
    OPD_NEG = 5'h17,
    OPD_ADD = 5'h18,
    OPD_SUB = 5'h19,
    OPD_MUL = 5'h1A,
    OPD_DIV = 5'h1B,
    OPD_MOD = 5'h1C,
    OPD_LD  = 5'h1D,
    OPD_STR = 5'h1E
  } opcode_e;

  typedef struct packed {
    logic c;
    logic s;
    logic o;
    logic z;
  } flags_t;

  function automatic logic is_alu_op(input logic [OPCODE_BITS-1:0] op);
    return op inside {OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NEG, OP_ADD, OP_SUB,
                      OP_MUL, OP_DIV, OP_MOD, OPD_NOT, OPD_AND, OPD_OR, OPD_XOR,
                      OPD_NEG, OPD_ADD, OPD_SUB, OPD_MUL, OPD_DIV, OPD_MOD};
  endfunction

  function automatic logic is_ld_op(input logic [OPCODE_BITS-1:0] op);
    return op inside {OP_LD, OPD_LD};
  endfunction

  function automatic logic is_str_op(input logic [OPCODE_BITS-1:0] op);
    return op inside {OP_STR, OPD_STR};
  endfunction

  function automatic logic is_jcc_op(input logic [OPCODE_BITS-1:0] op);
    return op inside {OP_JC, OP_JS, OP_JO, OP_JZ};
  endfunction

  // Conditional jumps test the committed flags, never the incoming bundle.
  function automatic logic jcc_taken(input logic [OPCODE_BITS-1:0] op, input flags_t f);
    case (op)
      OP_JC:   return f.c;
      OP_JS:   return f.s;
      OP_JO:   return f.o;
      OP_JZ:   return f.z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// ALU-result input bundle and register-file write port of the writeback stage.
interface alu_writeback_stage_if #(
    parameter int BITS_DATA     = 32,
    parameter int REG_ADDR_BITS = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [4:0]               in_opcode;
    logic [BITS_DATA-1:0]     in_result;
    logic                     in_c;
    logic                     in_s;
    logic                     in_o;
    logic                     in_z;
    logic [REG_ADDR_BITS-1:0] in_dest;
    logic [BITS_DATA-1:0]     in_target;

    logic                     rf_valid;
    logic                     rf_ready;
    logic [REG_ADDR_BITS-1:0] rf_addr;
    logic [BITS_DATA-1:0]     rf_data;

    modport master (
        output in_valid, in_opcode, in_result, in_c, in_s, in_o, in_z, in_dest, in_target,
        input  in_ready,
        input  rf_valid, rf_addr, rf_data,
        output rf_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_result, in_c, in_s, in_o, in_z, in_dest, in_target,
        output in_ready,
        output rf_valid, rf_addr, rf_data,
        input  rf_ready
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry valid/ready FIFO that lets the register-file port stall without
// losing results already accepted from the ALU.
module wb_skid_fifo #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset on purpose - the head entry drives rf_addr/rf_data,
            // which must read zero out of reset; at two entries this costs nothing.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage after the ALU: commits flags, queues register writes,
// resolves jumps against committed flags and latches HLT.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int BITS_DATA     = 32,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_writeback_stage_if.slave bus,
    output logic                 flag_c,
    output logic                 flag_s,
    output logic                 flag_o,
    output logic                 flag_z,
    output logic                 pc_load,
    output logic [BITS_DATA-1:0] pc_target,
    output logic                 halted,
    output logic                 err_x
);
    localparam int ENTRY_BITS = REG_ADDR_BITS + BITS_DATA;

    flags_t                 flags_q, flags_d;
    logic                   halted_q, halted_d;
    logic                   err_x_q, err_x_d;
    logic                   pc_load_q, pc_load_d;
    logic [BITS_DATA-1:0]   pc_target_q, pc_target_d;
    logic                   fifo_in_ready;
    logic                   fire;
    logic                   push;
    logic [ENTRY_BITS-1:0]  head;

    assign bus.in_ready = rst_n & ~halted_q & fifo_in_ready;
    assign fire         = bus.in_valid & bus.in_ready;

    always_comb begin
        flags_d     = flags_q;
        halted_d    = halted_q;
        err_x_d     = err_x_q;
        pc_load_d   = 1'b0;
        pc_target_d = pc_target_q;
        push        = 1'b0;
        if (fire) begin
            if (is_alu_op(bus.in_opcode)) begin
                flags_d = '{c: bus.in_c, s: bus.in_s, o: bus.in_o, z: bus.in_z};
                push    = 1'b1;
                // An unknown flag poisons the XOR reduction; synthesis folds this to 0.
                if ((^{bus.in_c, bus.in_s, bus.in_o, bus.in_z}) === 1'bx) begin
                    err_x_d = 1'b1;
                end
            end else if (is_ld_op(bus.in_opcode)) begin
                push = 1'b1;
            end else if (bus.in_opcode == OP_JMP ||
                         (is_jcc_op(bus.in_opcode) && jcc_taken(bus.in_opcode, flags_q))) begin
                pc_load_d   = 1'b1;
                pc_target_d = bus.in_target;
            end else if (bus.in_opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= '0;
            halted_q    <= 1'b0;
            err_x_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            flags_q     <= flags_d;
            halted_q    <= halted_d;
            err_x_q     <= err_x_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
        end
    end

    wb_skid_fifo #(.WIDTH(ENTRY_BITS)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (push),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({bus.in_dest, bus.in_result}),
        .out_valid_o (bus.rf_valid),
        .out_ready_i (bus.rf_ready),
        .out_data_o  (head)
    );

    assign bus.rf_addr = head[ENTRY_BITS-1 -: REG_ADDR_BITS];
    assign bus.rf_data = head[BITS_DATA-1:0];

    assign flag_c    = flags_q.c;
    assign flag_s    = flags_q.s;
    assign flag_o    = flags_q.o;
    assign flag_z    = flags_q.z;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign halted    = halted_q;
    assign err_x     = err_x_q;
endmodule
